// File: rtl/hack_cpu_mc.sv
// hack_cpu_mc -- multi-cycle Hack CPU core with req/ack instruction and data
// memory ports. Each instruction walks FETCH -> DECODE -> [MEM_RD] -> EXEC ->
// [MEM_WR]; every memory phase waits for its ack, so any latency is tolerated.
//
// Ports:
//   clock, reset_n       sole clock (posedge), synchronous active-low reset
//   hold                 blocks the start of a new fetch (never aborts one)
//   imem_req/addr/ack/rdata         instruction fetch handshake (addr == pc)
//   dmem_req/we/addr/wdata/ack/rdata data read/write handshake
//   pc                   program counter
//   retire               high for the cycle an instruction completes
//   cycle_count, instr_count (only with HACK_CPU_MC_PERF_EN defined)
//
// Optional build macro: HACK_CPU_MC_PERF_EN adds wrapping 32-bit cycle and
// retired-instruction counters.
module hack_cpu_mc #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 15
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  hold,
  output logic                  imem_req,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic                  imem_ack,
  input  logic [15:0]           imem_rdata,
  output logic                  dmem_req,
  output logic                  dmem_we,
  output logic [ADDR_WIDTH-1:0] dmem_addr,
  output logic [DATA_WIDTH-1:0] dmem_wdata,
  input  logic                  dmem_ack,
  input  logic [DATA_WIDTH-1:0] dmem_rdata,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic                  retire
`ifdef HACK_CPU_MC_PERF_EN
  ,
  output logic [31:0]           cycle_count,
  output logic [31:0]           instr_count
`endif
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_MEM_RD = 3'd3;
  localparam logic [2:0] S_EXEC   = 3'd4;
  localparam logic [2:0] S_MEM_WR = 3'd5;

  logic [2:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [DATA_WIDTH-1:0] a_q, a_d, d_q, d_d, m_q, m_d;
  logic [15:0]           ir_q, ir_d;
  logic [ADDR_WIDTH-1:0] daddr_q, daddr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;

  // ALU always sees the pre-EXEC A/D, so AM=/AMD=/A=..;JMP keep Hack semantics.
  logic [DATA_WIDTH-1:0] alu_x, alu_y, alu_out;
  logic                  zr, ng, jump;

  always_comb begin
    alu_x = d_q;
    alu_y = ir_q[12] ? m_q : a_q;
    if (ir_q[11]) alu_x = '0;
    if (ir_q[10]) alu_x = ~alu_x;
    if (ir_q[9])  alu_y = '0;
    if (ir_q[8])  alu_y = ~alu_y;
    alu_out = ir_q[7] ? (alu_x + alu_y) : (alu_x & alu_y);
    if (ir_q[6])  alu_out = ~alu_out;
    zr   = (alu_out == '0);
    ng   = alu_out[DATA_WIDTH-1];
    jump = (ir_q[2] & ng) | (ir_q[1] & zr) | (ir_q[0] & ~ng & ~zr);
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    a_d     = a_q;
    d_d     = d_q;
    m_d     = m_q;
    ir_d    = ir_q;
    daddr_d = daddr_q;
    wdata_d = wdata_q;
    retire  = 1'b0;
    case (state_q)
      S_IDLE: if (!hold) state_d = S_FETCH;
      S_FETCH: if (imem_ack) begin
        ir_d    = imem_rdata;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        if (!ir_q[15]) begin
          a_d     = DATA_WIDTH'(ir_q[14:0]);
          pc_d    = pc_q + ADDR_WIDTH'(1);
          retire  = 1'b1;
          state_d = hold ? S_IDLE : S_FETCH;
        end else if (ir_q[12]) begin
          // address registered here so dmem_addr is stable for the whole read
          daddr_d = a_q[ADDR_WIDTH-1:0];
          state_d = S_MEM_RD;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_MEM_RD: if (dmem_ack) begin
        m_d     = dmem_rdata;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        if (ir_q[5]) a_d = alu_out;
        if (ir_q[4]) d_d = alu_out;
        pc_d = jump ? a_q[ADDR_WIDTH-1:0] : pc_q + ADDR_WIDTH'(1);
        if (ir_q[3]) begin
          daddr_d = a_q[ADDR_WIDTH-1:0];
          wdata_d = alu_out;
          state_d = S_MEM_WR;
        end else begin
          retire  = 1'b1;
          state_d = hold ? S_IDLE : S_FETCH;
        end
      end
      S_MEM_WR: if (dmem_ack) begin
        retire  = 1'b1;
        state_d = hold ? S_IDLE : S_FETCH;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      a_q     <= '0;
      d_q     <= '0;
      m_q     <= '0;
      ir_q    <= '0;
      daddr_q <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      a_q     <= a_d;
      d_q     <= d_d;
      m_q     <= m_d;
      ir_q    <= ir_d;
      daddr_q <= daddr_d;
      wdata_q <= wdata_d;
    end
  end

  // Requests are pure state decodes: no ack-to-req combinational path.
  assign imem_req   = (state_q == S_FETCH);
  assign imem_addr  = pc_q;
  assign dmem_req   = (state_q == S_MEM_RD) || (state_q == S_MEM_WR);
  assign dmem_we    = (state_q == S_MEM_WR);
  assign dmem_addr  = daddr_q;
  assign dmem_wdata = wdata_q;
  assign pc         = pc_q;

`ifdef HACK_CPU_MC_PERF_EN
  logic [31:0] cyc_cnt_q, cyc_cnt_d, ins_cnt_q, ins_cnt_d;

  always_comb begin
    cyc_cnt_d = cyc_cnt_q + 32'(!hold);
    ins_cnt_d = ins_cnt_q + 32'(retire);
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      cyc_cnt_q <= '0;
      ins_cnt_q <= '0;
    end else begin
      cyc_cnt_q <= cyc_cnt_d;
      ins_cnt_q <= ins_cnt_d;
    end
  end

  assign cycle_count = cyc_cnt_q;
  assign instr_count = ins_cnt_q;
`endif

endmodule

// File: tb/tb_hack_cpu_mc.sv
// Directed bench for hack_cpu_mc: a table of small programs with hand-computed
// final A/D/pc and bus activity, plus hand sequences for hold and mid-write reset.
module tb_hack_cpu_mc;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        hold_user = 1'b0;
  logic        auto_hold = 1'b0;
  logic        hold;
  logic        imem_req, imem_ack = 1'b0;
  logic [14:0] imem_addr;
  logic [15:0] imem_rdata = '0;
  logic        dmem_req, dmem_we, dmem_ack = 1'b0;
  logic [14:0] dmem_addr;
  logic [15:0] dmem_wdata, dmem_rdata = '0;
  logic [14:0] pc;
  logic        retire;
`ifdef HACK_CPU_MC_PERF_EN
  logic [31:0] cycle_count, instr_count;
`endif

  assign hold = hold_user | auto_hold;
  always #5 clock = ~clock;

  hack_cpu_mc #(.DATA_WIDTH(16), .ADDR_WIDTH(15)) dut (
    .clock(clock), .reset_n(reset_n), .hold(hold),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .pc(pc), .retire(retire)
`ifdef HACK_CPU_MC_PERF_EN
    , .cycle_count(cycle_count), .instr_count(instr_count)
`endif
  );

  typedef struct {
    logic [3:0][15:0] prog;
    int               n_ret;
    int               iw, dw;
    logic [15:0]      ram, top;
    logic [15:0]      ea, ed;
    logic [14:0]      epc;
    int               ewr;
    logic [14:0]      ewa;
    logic [15:0]      ewd;
    int               erd;
    bit               chk_rc;
  } vec_t;

  // memory model configuration (written by the test, read by the model)
  logic [3:0][15:0] prog_cur = '0;
  logic [15:0]      top_cur = '0, ram_cur = '0;
  int               iwait = 0, dwait = 0;

  int total = 0, bad = 0;
  int pcnt = 0, base = 0;
  int nret = 0, ret_base = 0, stop_at = 1000;
  int nwr = 0, nrd = 0, nchg = 0;
  logic [14:0] last_wa = '0;
  logic [15:0] last_wd = '0;
  int rc [8];

  function automatic logic [15:0] fetch_word(input logic [14:0] a);
    if (a < 15'd4) return prog_cur[a[1:0]];
    if (a == 15'h7FFF) return top_cur;
    return 16'h0000;
  endfunction

  // Memory responders: decide each ack just after the edge that raised the req.
  int icnt = 0, dcnt = 0;
  always begin
    @(posedge clock);
    pcnt++;
    #1;
    if (imem_req) begin
      if (icnt == iwait) begin imem_ack = 1'b1; imem_rdata = fetch_word(imem_addr); icnt = 0; end
      else begin imem_ack = 1'b0; icnt++; end
    end else begin imem_ack = 1'b0; icnt = 0; end
    if (dmem_req) begin
      if (dcnt == dwait) begin dmem_ack = 1'b1; dmem_rdata = ram_cur; dcnt = 0; end
      else begin dmem_ack = 1'b0; dcnt++; end
    end else begin dmem_ack = 1'b0; dcnt = 0; end
  end

  // Bus monitor, sampled mid-cycle.
  logic        prev_pend = 1'b0;
  logic [14:0] prev_addr = '0;
  logic [15:0] prev_wd = '0;
  always @(negedge clock) begin
    if (reset_n) begin
      if (retire) begin
        if (nret - ret_base < 8) rc[nret - ret_base] = pcnt - base;
        nret++;
      end
      if (dmem_req && dmem_we && dmem_ack) begin nwr++; last_wa = dmem_addr; last_wd = dmem_wdata; end
      if (dmem_req && !dmem_we) nrd++;
      if (dmem_req && prev_pend && (dmem_addr != prev_addr || (dmem_we && dmem_wdata != prev_wd))) nchg++;
    end
    prev_pend = dmem_req && !dmem_ack;
    prev_addr = dmem_addr;
    prev_wd   = dmem_wdata;
    auto_hold = (nret - ret_base) >= stop_at;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic start_run(input logic [3:0][15:0] p, input logic [15:0] top,
                           input logic [15:0] ram, input int iw, input int dw, input int n);
    reset_n = 1'b0;
    hold_user = 1'b0;
    prog_cur = p; top_cur = top; ram_cur = ram; iwait = iw; dwait = dw;
    stop_at = n;
    ret_base = nret;
    repeat (2) @(posedge clock);
    #2;
    reset_n = 1'b1;
    base = pcnt;
  endtask

  task automatic wait_ret(input string name, input int n);
    int k;
    k = 0;
    while ((nret - ret_base) < n && k < 400) begin @(negedge clock); k++; end
    chk({name, " retire timeout"}, 32'((nret - ret_base) >= n), 32'd1);
  endtask

  vec_t vecs [10];

  function automatic vec_t mk(input logic [3:0][15:0] p, input int n, input int iw, input int dw,
                              input logic [15:0] ram, input logic [15:0] top,
                              input logic [15:0] ea, input logic [15:0] ed, input logic [14:0] epc,
                              input int ewr, input logic [14:0] ewa, input logic [15:0] ewd,
                              input int erd, input bit crc);
    vec_t v;
    v.prog = p; v.n_ret = n; v.iw = iw; v.dw = dw; v.ram = ram; v.top = top;
    v.ea = ea; v.ed = ed; v.epc = epc; v.ewr = ewr; v.ewa = ewa; v.ewd = ewd;
    v.erd = erd; v.chk_rc = crc;
    return v;
  endfunction

  initial begin
    int w0, r0, c0, cnt;
    string nm;
    // prog words listed {p3, p2, p1, p0}
    vecs[0] = mk({16'hE308, 16'h0007, 16'hEC10, 16'h0005}, 4, 0, 0, 16'h0, 16'h0, 16'd7, 16'd5, 15'd4, 1, 15'd7, 16'd5, 0, 1); // @5;D=A;@7;M=D
    vecs[1] = mk({16'h0000, 16'h0000, 16'hFC10, 16'h0003}, 2, 0, 4, 16'h1234, 16'h0, 16'd3, 16'h1234, 15'd2, 0, 15'd0, 16'd0, 5, 0); // @3;D=M slow
    vecs[2] = mk({16'h0000, 16'hE304, 16'hEE90, 16'h0014}, 3, 0, 0, 16'h0, 16'h0, 16'd20, 16'hFFFF, 15'd20, 0, 15'd0, 16'd0, 0, 0); // JLT taken
    vecs[3] = mk({16'h0000, 16'hE301, 16'hEE90, 16'h0014}, 3, 0, 0, 16'h0, 16'h0, 16'd20, 16'hFFFF, 15'd3, 0, 15'd0, 16'd0, 0, 0); // JGT not
    vecs[4] = mk({16'h0000, 16'h0000, 16'hEDE8, 16'h0009}, 2, 0, 0, 16'h0, 16'h0, 16'd10, 16'd0, 15'd2, 1, 15'd9, 16'd10, 0, 0); // @9;AM=A+1
    vecs[5] = mk({16'hF098, 16'h0004, 16'hEC10, 16'h0006}, 4, 0, 2, 16'h0010, 16'h0, 16'd4, 16'h0016, 15'd4, 1, 15'd4, 16'h0016, 3, 0); // MD=D+M
    vecs[6] = mk({16'hE327, 16'h000B, 16'hEC10, 16'h0006}, 4, 0, 0, 16'h0, 16'h0, 16'd6, 16'd6, 15'd11, 0, 15'd0, 16'd0, 0, 0); // A=D;JMP old A
    vecs[7] = mk({16'hE302, 16'h000F, 16'hEC10, 16'h0000}, 4, 0, 0, 16'h0, 16'h0, 16'd15, 16'd0, 15'd15, 0, 15'd0, 16'd0, 0, 0); // D;JEQ
    vecs[8] = mk({16'h0000, 16'h0000, 16'hFC10, 16'h0003}, 2, 3, 0, 16'h1234, 16'h0, 16'd3, 16'h1234, 15'd2, 0, 15'd0, 16'd0, 1, 0); // slow fetch
    vecs[9] = mk({16'h0000, 16'h0000, 16'hEA87, 16'h7FFF}, 3, 0, 0, 16'h0, 16'h0003, 16'd3, 16'd0, 15'd0, 0, 15'd0, 16'd0, 0, 0); // pc wrap

    // reset state
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("rst imem_req", 32'(imem_req), 32'd0);
    chk("rst dmem_req", 32'(dmem_req), 32'd0);
    chk("rst dmem_we", 32'(dmem_we), 32'd0);
    chk("rst retire", 32'(retire), 32'd0);
    chk("rst pc", 32'(pc), 32'd0);
    chk("rst dmem_addr", 32'(dmem_addr), 32'd0);
    chk("rst dmem_wdata", 32'(dmem_wdata), 32'd0);

    for (int i = 0; i < 10; i++) begin
      nm = $sformatf("v%0d", i);
      w0 = nwr; r0 = nrd; c0 = nchg;
      start_run(vecs[i].prog, vecs[i].top, vecs[i].ram, vecs[i].iw, vecs[i].dw, vecs[i].n_ret);
      wait_ret(nm, vecs[i].n_ret);
      repeat (4) @(negedge clock);
      chk({nm, " A"}, 32'(dut.a_q), 32'(vecs[i].ea));
      chk({nm, " D"}, 32'(dut.d_q), 32'(vecs[i].ed));
      chk({nm, " pc"}, 32'(pc), 32'(vecs[i].epc));
      chk({nm, " retires"}, 32'(nret - ret_base), 32'(vecs[i].n_ret));
      chk({nm, " writes"}, 32'(nwr - w0), 32'(vecs[i].ewr));
      if (vecs[i].ewr != 0) begin
        chk({nm, " waddr"}, 32'(last_wa), 32'(vecs[i].ewa));
        chk({nm, " wdata"}, 32'(last_wd), 32'(vecs[i].ewd));
      end
      chk({nm, " read cycles"}, 32'(nrd - r0), 32'(vecs[i].erd));
      chk({nm, " bus stable"}, 32'(nchg - c0), 32'd0);
      if (vecs[i].chk_rc) begin
        chk({nm, " rc0"}, 32'(rc[0]), 32'd2);
        chk({nm, " rc1"}, 32'(rc[1]), 32'd5);
        chk({nm, " rc2"}, 32'(rc[2]), 32'd7);
        chk({nm, " rc3"}, 32'(rc[3]), 32'd11);
`ifdef HACK_CPU_MC_PERF_EN
        chk({nm, " cycle_count"}, cycle_count, 32'd11);
`endif
      end
`ifdef HACK_CPU_MC_PERF_EN
      chk({nm, " instr_count"}, instr_count, 32'(vecs[i].n_ret));
`endif
    end

    // hold raised while a slow fetch is pending
    start_run({16'h0, 16'h0, 16'h0008, 16'h0005}, 16'h0, 16'h0, 3, 0, 1000);
    @(posedge clock);
    @(negedge clock);
    hold_user = 1'b1;
    repeat (8) @(negedge clock);
    chk("hold retires", 32'(nret - ret_base), 32'd1);
    chk("hold pc", 32'(pc), 32'd1);
    cnt = 0;
    for (int k = 0; k < 5; k++) begin @(negedge clock); if (imem_req) cnt++; end
    chk("hold no fetch", 32'(cnt), 32'd0);
    hold_user = 1'b0;
    wait_ret("hold release", 2);
    @(negedge clock);
    chk("hold release pc", 32'(pc), 32'd2);
    chk("hold release A", 32'(dut.a_q), 32'd8);
    hold_user = 1'b1;

    // reset while a write is waiting for its ack
    w0 = nwr;
    start_run({16'h0, 16'h0, 16'hE308, 16'h0007}, 16'h0, 16'h0, 0, 10, 1000);
    cnt = 0;
    while (!(dmem_req && dmem_we) && cnt < 100) begin @(negedge clock); cnt++; end
    chk("mw reached MEM_WR", 32'(dmem_req && dmem_we), 32'd1);
    @(negedge clock);
    reset_n = 1'b0;
    hold_user = 1'b1;
    @(negedge clock);
    chk("mw dmem_req dropped", 32'(dmem_req), 32'd0);
    chk("mw pc", 32'(pc), 32'd0);
    chk("mw A", 32'(dut.a_q), 32'd0);
`ifdef HACK_CPU_MC_PERF_EN
    chk("mw instr_count", instr_count, 32'd0);
`endif
    reset_n = 1'b1;
    repeat (15) @(negedge clock);
    chk("mw no write", 32'(nwr - w0), 32'd0);
    chk("mw idle pc", 32'(pc), 32'd0);
    chk("mw idle req", 32'(dmem_req | imem_req), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
